// File: rtl/mips_control_mc.sv
// Multicycle MIPS control FSM with configurable memory latency, BEQ/BNE
// and optional precise exceptions (illegal opcode, arithmetic overflow).
module mips_control_mc #(
  parameter int unsigned MEM_LAT = 3,
  parameter bit          EN_EXC  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic       pc_load,
  output logic       mem_write,
  output logic       ins_load,
  output logic       reg_write,
  output logic       regA_load,
  output logic       regB_load,
  output logic       aluout_load,
  output logic       mdr_load,
  output logic       epc_load,
  output logic       mux_alusrcA,
  output logic       mux_IorD,
  output logic [1:0] mux_alusrcB,
  output logic [1:0] mux_regdst,
  output logic [1:0] mux_mem2reg,
  output logic [2:0] mux_pcin,
  output logic [2:0] alu_op,
  output logic [1:0] adjsz_ctrl,
  output logic [1:0] memow_ctrl,
  output logic [1:0] cause,
  output logic       busy_wait
);

  localparam int unsigned WCNT_W = 4;
  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(MEM_LAT - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] CAUSE_ILL = 2'd1;
  localparam logic [1:0] CAUSE_OVF = 2'd2;

  typedef enum logic [4:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_WB_R, ST_WB_I,
    ST_LUI, ST_ADDR_LD, ST_ADDR_ST, ST_MEM_RD, ST_MEM_WR, ST_WB_MEM,
    ST_BRANCH, ST_JUMP, ST_JAL, ST_JR, ST_EXC
  } state_t;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [1:0]        cause_nxt;
  logic              wait_last;
  logic [2:0]        r_alu_op;
  logic              r_legal;
  logic              r_ovf_chk;
  logic [1:0]        adjsz_sel;
  logic [1:0]        memow_sel;

  // R-type funct decode, shared by EXEC_R output and exception checks
  always_comb begin
    r_alu_op  = 3'd0;
    r_legal   = 1'b1;
    r_ovf_chk = 1'b0;
    case (funct)
      FN_ADD:  begin r_alu_op = 3'd1; r_ovf_chk = 1'b1; end
      FN_SUB:  begin r_alu_op = 3'd2; r_ovf_chk = 1'b1; end
      FN_AND:  r_alu_op = 3'd3;
      FN_OR:   r_alu_op = 3'd4;
      FN_SLT:  r_alu_op = 3'd5;
      default: r_legal = 1'b0;
    endcase
  end

  // Access size for load-adjust and store-write-enable datapath blocks
  always_comb begin
    adjsz_sel = 2'd0;
    memow_sel = 2'd0;
    case (opcode)
      OP_LB:   adjsz_sel = 2'd1;
      OP_LH:   adjsz_sel = 2'd2;
      default: adjsz_sel = 2'd0;
    endcase
    case (opcode)
      OP_SB:   memow_sel = 2'd1;
      OP_SH:   memow_sel = 2'd2;
      default: memow_sel = 2'd0;
    endcase
  end

  assign wait_last = (wcnt == '0);

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt   = state;
    cause_nxt   = cause;
    pc_load     = 1'b0;
    mem_write   = 1'b0;
    ins_load    = 1'b0;
    reg_write   = 1'b0;
    regA_load   = 1'b0;
    regB_load   = 1'b0;
    aluout_load = 1'b0;
    mdr_load    = 1'b0;
    epc_load    = 1'b0;
    mux_alusrcA = 1'b0;
    mux_IorD    = 1'b0;
    mux_alusrcB = 2'd0;
    mux_regdst  = 2'd0;
    mux_mem2reg = 2'd0;
    mux_pcin    = 3'd0;
    alu_op      = 3'd0;
    adjsz_ctrl  = 2'd0;
    memow_ctrl  = 2'd0;
    busy_wait   = 1'b0;

    case (state)
      ST_RESET: state_nxt = ST_FETCH;

      ST_FETCH: begin
        mux_IorD    = 1'b0;
        mux_alusrcA = 1'b0;
        mux_alusrcB = 2'd1;
        alu_op      = 3'd1;
        busy_wait   = !wait_last;
        if (wait_last) begin
          ins_load  = 1'b1;
          pc_load   = 1'b1;
          mux_pcin  = 3'd0;
          state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
        regA_load   = 1'b1;
        regB_load   = 1'b1;
        aluout_load = 1'b1;
        mux_alusrcA = 1'b0;
        mux_alusrcB = 2'd3;
        alu_op      = 3'd1;
        case (opcode)
          OP_RTYPE:            state_nxt = (funct == FN_JR) ? ST_JR : ST_EXEC_R;
          OP_ADDI:             state_nxt = ST_EXEC_I;
          OP_LUI:              state_nxt = ST_LUI;
          OP_LB, OP_LH, OP_LW: state_nxt = ST_ADDR_LD;
          OP_SB, OP_SH, OP_SW: state_nxt = ST_ADDR_ST;
          OP_BEQ, OP_BNE:      state_nxt = ST_BRANCH;
          OP_J:                state_nxt = ST_JUMP;
          OP_JAL:              state_nxt = ST_JAL;
          default: begin
            if (EN_EXC) begin
              state_nxt = ST_EXC;
              cause_nxt = CAUSE_ILL;
            end else begin
              state_nxt = ST_FETCH;
            end
          end
        endcase
      end

      ST_EXEC_R: begin
        mux_alusrcA = 1'b1;
        mux_alusrcB = 2'd0;
        aluout_load = 1'b1;
        alu_op      = r_alu_op;
        if (!r_legal) begin
          if (EN_EXC) begin
            state_nxt = ST_EXC;
            cause_nxt = CAUSE_ILL;
          end else begin
            state_nxt = ST_FETCH;
          end
        end else if (EN_EXC && r_ovf_chk && alu_overflow) begin
          state_nxt = ST_EXC;
          cause_nxt = CAUSE_OVF;
        end else begin
          state_nxt = ST_WB_R;
        end
      end

      ST_EXEC_I: begin
        mux_alusrcA = 1'b1;
        mux_alusrcB = 2'd2;
        aluout_load = 1'b1;
        alu_op      = 3'd1;
        if (EN_EXC && alu_overflow) begin
          state_nxt = ST_EXC;
          cause_nxt = CAUSE_OVF;
        end else begin
          state_nxt = ST_WB_I;
        end
      end

      ST_WB_R: begin
        reg_write   = 1'b1;
        mux_regdst  = 2'd1;
        mux_mem2reg = 2'd1;
        state_nxt   = ST_FETCH;
      end

      ST_WB_I: begin
        reg_write   = 1'b1;
        mux_regdst  = 2'd0;
        mux_mem2reg = 2'd1;
        state_nxt   = ST_FETCH;
      end

      ST_LUI: begin
        reg_write   = 1'b1;
        mux_regdst  = 2'd0;
        mux_mem2reg = 2'd2;
        state_nxt   = ST_FETCH;
      end

      ST_ADDR_LD, ST_ADDR_ST: begin
        mux_alusrcA = 1'b1;
        mux_alusrcB = 2'd2;
        alu_op      = 3'd1;
        aluout_load = 1'b1;
        state_nxt   = (state == ST_ADDR_LD) ? ST_MEM_RD : ST_MEM_WR;
      end

      ST_MEM_RD: begin
        mux_IorD   = 1'b1;
        adjsz_ctrl = adjsz_sel;
        busy_wait  = !wait_last;
        if (wait_last) begin
          mdr_load  = 1'b1;
          state_nxt = ST_WB_MEM;
        end
      end

      ST_WB_MEM: begin
        reg_write   = 1'b1;
        mux_regdst  = 2'd0;
        mux_mem2reg = 2'd0;
        adjsz_ctrl  = adjsz_sel;
        state_nxt   = ST_FETCH;
      end

      ST_MEM_WR: begin
        mux_IorD   = 1'b1;
        mem_write  = 1'b1;
        memow_ctrl = memow_sel;
        busy_wait  = !wait_last;
        if (wait_last) state_nxt = ST_FETCH;
      end

      // BNE (opcode[0]=1) inverts the zero test
      ST_BRANCH: begin
        mux_alusrcA = 1'b1;
        mux_alusrcB = 2'd0;
        alu_op      = 3'd2;
        mux_pcin    = 3'd1;
        pc_load     = alu_zero ^ opcode[0];
        state_nxt   = ST_FETCH;
      end

      ST_JUMP: begin
        pc_load   = 1'b1;
        mux_pcin  = 3'd2;
        state_nxt = ST_FETCH;
      end

      ST_JAL: begin
        reg_write   = 1'b1;
        mux_regdst  = 2'd3;
        mux_mem2reg = 2'd3;
        pc_load     = 1'b1;
        mux_pcin    = 3'd2;
        state_nxt   = ST_FETCH;
      end

      ST_JR: begin
        pc_load   = 1'b1;
        mux_pcin  = 3'd3;
        state_nxt = ST_FETCH;
      end

      ST_EXC: begin
        epc_load  = 1'b1;
        pc_load   = 1'b1;
        mux_pcin  = 3'd4;
        state_nxt = ST_FETCH;
      end

      default: state_nxt = ST_RESET;
    endcase
  end

  // State, wait counter (reloaded on every state change) and cause register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RESET;
      wcnt  <= '0;
      cause <= 2'd0;
    end else begin
      state <= state_nxt;
      cause <= cause_nxt;
      if (state_nxt != state) begin
        wcnt <= WCNT_INIT;
      end else if (wcnt != '0) begin
        wcnt <= wcnt - WCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_control_mc.sv
// Bench for mips_control_mc: three builds (M=3/exc, M=3/no-exc, M=1/exc)
// checked cycle by cycle against an instruction-level expected-trace model.
module tb_mips_control_mc;

  typedef struct packed {
    logic       pc_load, mem_write, ins_load, reg_write, rega_load, regb_load;
    logic       aluout_load, mdr_load, epc_load, busy_wait;
    logic       alusrca, iord;
    logic [1:0] alusrcb, regdst, mem2reg;
    logic [2:0] pcin, alu_op;
    logic [1:0] adjsz, memow, cause;
  } obs_t;

  typedef struct packed {
    obs_t v;
    obs_t m;
  } step_t;

  localparam int   NDUT = 3;
  localparam obs_t BASE = {10'h3FF, 18'd0, 2'b11};

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       alu_zero, alu_overflow;
  obs_t       obs [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned ML = (g == 2) ? 1 : 3;
    localparam bit          EE = (g != 1);
    logic       pc_load, mem_write, ins_load, reg_write, regA_load, regB_load;
    logic       aluout_load, mdr_load, epc_load, mux_alusrcA, mux_IorD, busy_wait;
    logic [1:0] mux_alusrcB, mux_regdst, mux_mem2reg, adjsz_ctrl, memow_ctrl, cause;
    logic [2:0] mux_pcin, alu_op;

    mips_control_mc #(.MEM_LAT(ML), .EN_EXC(EE)) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
      .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .pc_load(pc_load), .mem_write(mem_write), .ins_load(ins_load),
      .reg_write(reg_write), .regA_load(regA_load), .regB_load(regB_load),
      .aluout_load(aluout_load), .mdr_load(mdr_load), .epc_load(epc_load),
      .mux_alusrcA(mux_alusrcA), .mux_IorD(mux_IorD), .mux_alusrcB(mux_alusrcB),
      .mux_regdst(mux_regdst), .mux_mem2reg(mux_mem2reg), .mux_pcin(mux_pcin),
      .alu_op(alu_op), .adjsz_ctrl(adjsz_ctrl), .memow_ctrl(memow_ctrl),
      .cause(cause), .busy_wait(busy_wait)
    );

    assign obs[g] = {pc_load, mem_write, ins_load, reg_write, regA_load, regB_load,
                     aluout_load, mdr_load, epc_load, busy_wait,
                     mux_alusrcA, mux_IorD, mux_alusrcB, mux_regdst, mux_mem2reg,
                     mux_pcin, alu_op, adjsz_ctrl, memow_ctrl, cause};
  end

  int         checks = 0;
  int         errors = 0;
  int         cur = 0;
  logic [1:0] cause_m = 2'd0;
  step_t      exp_q [$];

  logic [5:0] op_tab [13] = '{6'h00, 6'h08, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h28,
                              6'h29, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
  logic [5:0] fn_tab [6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08};

  function automatic int lat_of(input int i);
    return (i == 2) ? 1 : 3;
  endfunction

  function automatic bit en_of(input int i);
    return i != 1;
  endfunction

  task automatic compare(input string tag, input obs_t v, input obs_t m);
    obs_t o;
    o = obs[cur];
    checks++;
    assert (((o ^ v) & m) === '0) else begin
      errors++;
      $error("FAIL %s dut%0d observed %h required %h care %h", tag, cur, o, v, m);
    end
  endtask

  task automatic new_step(output obs_t v, output obs_t m);
    v = '0;
    m = BASE;
  endtask

  task automatic add_step(input obs_t v, input obs_t m);
    step_t s;
    v.cause = cause_m;
    s.v = v;
    s.m = m;
    exp_q.push_back(s);
  endtask

  task automatic build_fetch();
    obs_t v, m;
    int   n;
    n = lat_of(cur);
    for (int i = 0; i < n; i++) begin
      new_step(v, m);
      v.iord = 1'b0;     m.iord = 1'b1;
      v.alusrca = 1'b0;  m.alusrca = 1'b1;
      v.alusrcb = 2'd1;  m.alusrcb = '1;
      v.alu_op = 3'd1;   m.alu_op = '1;
      v.busy_wait = (i != n - 1);
      if (i == n - 1) begin
        v.ins_load = 1'b1;
        v.pc_load = 1'b1;
        v.pcin = 3'd0;   m.pcin = '1;
      end
      add_step(v, m);
    end
  endtask

  task automatic add_exc(input logic [1:0] c);
    obs_t v, m;
    cause_m = c;
    new_step(v, m);
    v.epc_load = 1'b1;
    v.pc_load = 1'b1;
    v.pcin = 3'd4;  m.pcin = '1;
    add_step(v, m);
  endtask

  task automatic add_wb(input logic [1:0] dst, input logic [1:0] src);
    obs_t v, m;
    new_step(v, m);
    v.reg_write = 1'b1;
    v.regdst = dst;   m.regdst = '1;
    v.mem2reg = src;  m.mem2reg = '1;
    add_step(v, m);
  endtask

  // Expected trace of one instruction from first FETCH cycle to its last cycle
  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic ov);
    obs_t v, m;
    int   n;
    bit   en, legal, arith;
    n  = lat_of(cur);
    en = en_of(cur);
    build_fetch();
    new_step(v, m);
    v.rega_load = 1'b1; v.regb_load = 1'b1; v.aluout_load = 1'b1;
    v.alusrca = 1'b0;   m.alusrca = 1'b1;
    v.alusrcb = 2'd3;   m.alusrcb = '1;
    v.alu_op = 3'd1;    m.alu_op = '1;
    add_step(v, m);
    case (op)
      6'h00: begin
        new_step(v, m);
        if (fn == 6'h08) begin
          v.pc_load = 1'b1;
          v.pcin = 3'd3; m.pcin = '1;
          add_step(v, m);
        end else begin
          legal = 1'b1;
          arith = (fn == 6'h20) || (fn == 6'h22);
          case (fn)
            6'h20: v.alu_op = 3'd1;
            6'h22: v.alu_op = 3'd2;
            6'h24: v.alu_op = 3'd3;
            6'h25: v.alu_op = 3'd4;
            6'h2A: v.alu_op = 3'd5;
            default: legal = 1'b0;
          endcase
          if (legal) m.alu_op = '1;
          v.alusrca = 1'b1;  m.alusrca = 1'b1;
          v.alusrcb = 2'd0;  m.alusrcb = '1;
          v.aluout_load = 1'b1;
          add_step(v, m);
          if (!legal) begin
            if (en) add_exc(2'd1);
          end else if (arith && en && ov) begin
            add_exc(2'd2);
          end else begin
            add_wb(2'd1, 2'd1);
          end
        end
      end
      6'h08: begin
        new_step(v, m);
        v.alusrca = 1'b1;  m.alusrca = 1'b1;
        v.alusrcb = 2'd2;  m.alusrcb = '1;
        v.alu_op = 3'd1;   m.alu_op = '1;
        v.aluout_load = 1'b1;
        add_step(v, m);
        if (en && ov) add_exc(2'd2);
        else add_wb(2'd0, 2'd1);
      end
      6'h0F: add_wb(2'd0, 2'd2);
      6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B: begin
        new_step(v, m);
        v.alusrca = 1'b1;  m.alusrca = 1'b1;
        v.alusrcb = 2'd2;  m.alusrcb = '1;
        v.alu_op = 3'd1;   m.alu_op = '1;
        v.aluout_load = 1'b1;
        add_step(v, m);
        for (int i = 0; i < n; i++) begin
          new_step(v, m);
          v.iord = 1'b1;  m.iord = 1'b1;
          v.busy_wait = (i != n - 1);
          if (op[3]) begin
            v.mem_write = 1'b1;
            v.memow = (op == 6'h28) ? 2'd1 : (op == 6'h29) ? 2'd2 : 2'd0;
            m.memow = '1;
          end else begin
            v.mdr_load = (i == n - 1);
            v.adjsz = (op == 6'h20) ? 2'd1 : (op == 6'h21) ? 2'd2 : 2'd0;
            m.adjsz = '1;
          end
          add_step(v, m);
        end
        if (!op[3]) begin
          new_step(v, m);
          v.reg_write = 1'b1;
          v.regdst = 2'd0;   m.regdst = '1;
          v.mem2reg = 2'd0;  m.mem2reg = '1;
          v.adjsz = (op == 6'h20) ? 2'd1 : (op == 6'h21) ? 2'd2 : 2'd0;
          m.adjsz = '1;
          add_step(v, m);
        end
      end
      6'h04, 6'h05: begin
        new_step(v, m);
        v.alusrca = 1'b1;  m.alusrca = 1'b1;
        v.alusrcb = 2'd0;  m.alusrcb = '1;
        v.alu_op = 3'd2;   m.alu_op = '1;
        v.pcin = 3'd1;     m.pcin = '1;
        v.pc_load = z ^ op[0];
        add_step(v, m);
      end
      6'h02: begin
        new_step(v, m);
        v.pc_load = 1'b1;
        v.pcin = 3'd2;  m.pcin = '1;
        add_step(v, m);
      end
      6'h03: begin
        new_step(v, m);
        v.reg_write = 1'b1;
        v.regdst = 2'd3;   m.regdst = '1;
        v.mem2reg = 2'd3;  m.mem2reg = '1;
        v.pc_load = 1'b1;
        v.pcin = 3'd2;     m.pcin = '1;
        add_step(v, m);
      end
      default: if (en) add_exc(2'd1);
    endcase
  endtask

  task automatic run_q(input string tag, input int n);
    step_t s;
    for (int k = 0; k < n; k++) begin
      s = exp_q.pop_front();
      @(negedge clk);
      compare($sformatf("%s c%0d", tag, k + 1), s.v, s.m);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input logic ov);
    opcode = op; funct = fn; alu_zero = z; alu_overflow = ov;
    build(op, fn, z, ov);
    run_q($sformatf("%s op%02h fn%02h z%0d v%0d", tag, op, fn, z, ov), exp_q.size());
  endtask

  // rst high for n+1 edges, then one RESET cycle with rst low; returns in FETCH
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      @(negedge clk);
      compare("reset_hold", '0, '1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    compare("reset_state", '0, '1);
    @(posedge clk); #1;
    cause_m = 2'd0;
    exp_q.delete();
  endtask

  task automatic rand_instr(input string tag);
    logic [5:0] op, fn;
    int         k;
    k  = $urandom_range(0, 13);
    op = (k == 13) ? 6'($urandom) : op_tab[k];
    k  = $urandom_range(0, 7);
    fn = (k >= 6) ? 6'($urandom) : fn_tab[k];
    do_instr(tag, op, fn, 1'($urandom), 1'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    step_t s;
    rst = 1'b1; opcode = '0; funct = '0; alu_zero = 1'b0; alu_overflow = 1'b0;

    // Build 0: M=3 with exceptions
    cur = 0;
    do_reset(1);
    do_instr("add", 6'h00, 6'h20, 1'b0, 1'b0);
    do_instr("add_ovf", 6'h00, 6'h20, 1'b0, 1'b1);
    do_instr("lh", 6'h21, 6'h00, 1'b0, 1'b0);
    do_instr("sb", 6'h28, 6'h00, 1'b0, 1'b0);
    do_instr("beq", 6'h04, 6'h00, 1'b1, 1'b0);
    do_instr("bne", 6'h05, 6'h00, 1'b1, 1'b0);
    do_instr("ill", 6'h3F, 6'h00, 1'b0, 1'b0);
    do_instr("jr", 6'h00, 6'h08, 1'b0, 1'b0);
    do_instr("j", 6'h02, 6'h11, 1'b0, 1'b0);
    do_instr("jal", 6'h03, 6'h00, 1'b0, 1'b0);
    do_instr("lui", 6'h0F, 6'h00, 1'b0, 1'b1);
    do_instr("addi_ovf", 6'h08, 6'h00, 1'b0, 1'b1);
    do_instr("badfn", 6'h00, 6'h3E, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) rand_instr("rnd0");

    // Reset in the second MEM_WR cycle
    opcode = 6'h2B; funct = '0; alu_zero = 1'b0; alu_overflow = 1'b0;
    build(6'h2B, 6'h00, 1'b0, 1'b0);
    run_q("sw_pre_rst", lat_of(cur) + 3);
    rst = 1'b1;
    s = exp_q.pop_front();
    @(negedge clk);
    compare("sw_wr2", s.v, s.m);
    do_reset(1);
    do_instr("add_after_rst", 6'h00, 6'h22, 1'b0, 1'b0);

    // Build 1: M=3 without exceptions
    cur = 1;
    do_reset(1);
    do_instr("ill_noexc", 6'h3F, 6'h00, 1'b0, 1'b0);
    do_instr("add_ovf_noexc", 6'h00, 6'h20, 1'b0, 1'b1);
    do_instr("badfn_noexc", 6'h00, 6'h01, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) rand_instr("rnd1");

    // Build 2: M=1 with exceptions
    cur = 2;
    do_reset(1);
    do_instr("add_m1", 6'h00, 6'h20, 1'b0, 1'b0);
    do_instr("lw_m1", 6'h23, 6'h00, 1'b0, 1'b0);
    do_instr("sh_m1", 6'h29, 6'h00, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) rand_instr("rnd2");
    build_fetch();
    run_q("final_fetch", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_control_mc.md
Name: mips_control_mc

Overview:
- Parametrised multicycle MIPS control FSM; next generation of the processor's existing control unit.
- Drives the same datapath handshake signals: PC, IR, register file, A/B, ALUOut, MDR and the datapath muxes.
- Adds three things:
  - configurable memory latency, using an internal wait counter instead of fixed padding states;
  - BEQ/BNE branches;
  - optional precise exceptions for illegal opcode and arithmetic overflow, with EPC/cause capture.

Parameters:
- MEM_LAT, 3: cycles from address presented to read data valid, or write committed. Legal range 1..15.
- EN_EXC, 1: 1 enables exceptions. 0 sends illegal opcodes back to FETCH, ignores overflow, and holds cause at 0.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU result == 0, combinational from datapath
- alu_overflow  in  1  signed overflow of current ALU op
- pc_load, mem_write, ins_load, reg_write, regA_load, regB_load, aluout_load, mdr_load, epc_load  out  1 each
- mux_alusrcA  out  1  0=PC, 1=A
- mux_IorD  out  1  0=PC, 1=ALUOut
- mux_alusrcB  out  2  0=B, 1=const 4, 2=sext(imm), 3=sext(imm)<<2
- mux_regdst  out  2  0=rt, 1=rd, 2=r29, 3=r31
- mux_mem2reg  out  2  0=MDR (size-adjusted), 1=ALUOut, 2=imm<<16, 3=PC
- mux_pcin  out  3  0=ALU result, 1=ALUOut, 2=jump target, 3=A, 4=exception vector
- alu_op  out  3  0=pass A, 1=add, 2=sub, 3=and, 4=or, 5=slt
- adjsz_ctrl  out  2  0=word, 1=byte, 2=half
- memow_ctrl  out  2  0=word, 1=byte, 2=half
- cause  out  2  0=none, 1=illegal opcode, 2=overflow
- busy_wait  out  1  high while the wait counter is running

Behaviour:
- Reset:
  - rst sampled at posedge; state<=RESET, wcnt<=0, cause<=0.
  - In RESET all outputs are 0. Next state is FETCH.
  - rst during any state, including mid-wait with mem_write high, forces RESET at that edge; mem_write is 0 in the following cycle.
- Outputs:
  - Moore decode of state, except two items: pc_load in BRANCH, and the opcode-derived size fields.
  - Any output not listed for a state is 0; any select not listed is don't-care.
- Wait counter:
  - Entering FETCH, MEM_RD or MEM_WR loads wcnt=MEM_LAT-1; wcnt decrements each cycle.
  - The "last" cycle is wcnt==0. busy_wait = in wait state and wcnt!=0.
- FETCH (MEM_LAT cycles): IorD=0, alusrcA=0, alusrcB=1, alu_op=add. On the last cycle only: ins_load=1, pc_load=1, pcin=0. Then DECODE.
- DECODE (1 cycle): regA_load=1, regB_load=1, aluout_load=1, alusrcA=0, alusrcB=3, alu_op=add (branch target). Dispatch on opcode:
  - 0x00 → EXEC_R; funct 0x08 → JR.
  - 0x08 → EXEC_I.
  - 0x0F → LUI.
  - 0x20/0x21/0x23 → ADDR_LD.
  - 0x28/0x29/0x2B → ADDR_ST.
  - 0x04/0x05 → BRANCH.
  - 0x02 → JUMP.
  - 0x03 → JAL.
  - Otherwise → EXC with cause=1 if EN_EXC, else → FETCH.
- EXEC_R: alusrcA=1, alusrcB=0, aluout_load=1.
  - alu_op by funct: 0x20→1, 0x22→2, 0x24→3, 0x25→4, 0x2A→5.
  - Unknown funct is illegal: EXC cause=1 if EN_EXC, else FETCH.
  - If funct ∈ {0x20,0x22}, EN_EXC=1 and alu_overflow=1 → EXC with cause=2.
  - Otherwise → WB_R.
- EXEC_I: as EXEC_R but alusrcB=2, alu_op=1; overflow check as above; then → WB_I.
- WB_R: reg_write=1, regdst=1, mem2reg=1. WB_I: reg_write=1, regdst=0, mem2reg=1. Both → FETCH.
- LUI: reg_write=1, regdst=0, mem2reg=2. → FETCH.
- ADDR_LD / ADDR_ST: alusrcA=1, alusrcB=2, alu_op=1, aluout_load=1. → MEM_RD / MEM_WR respectively.
- MEM_RD (MEM_LAT cycles): IorD=1; mdr_load=1 on the last cycle only. → WB_MEM.
- WB_MEM: reg_write=1, regdst=0, mem2reg=0. → FETCH.
- Size fields:
  - adjsz_ctrl from opcode (0x23→0, 0x20→1, 0x21→2), held through MEM_RD and WB_MEM.
  - memow_ctrl from opcode (0x2B→0, 0x28→1, 0x29→2), held through MEM_WR.
- MEM_WR (MEM_LAT cycles): IorD=1, mem_write=1 in every cycle. → FETCH.
- BRANCH (1 cycle): alusrcA=1, alusrcB=0, alu_op=2, pcin=1. pc_load = alu_zero XOR opcode[0]. → FETCH.
- JUMP: pc_load=1, pcin=2. → FETCH.
- JAL: reg_write=1, regdst=3, mem2reg=3 (PC already +4); pc_load=1, pcin=2. → FETCH.
- JR: pc_load=1, pcin=3. → FETCH.
- EXC (1 cycle): epc_load=1, pc_load=1, pcin=4, reg_write=0. cause is registered at entry and held until the next EXC or reset. → FETCH.
- Latencies with M=MEM_LAT:
  - R/I ALU ops: M+3 cycles.
  - LW/LH/LB: 2M+3.
  - SW/SH/SB: 2M+2.
  - BEQ/BNE, J, JAL, JR: M+2.
  - Exception: M+2 from DECODE, M+3 from EXEC.

Test Plan:
- M=3, reset held 2 cycles, release → all outputs 0 in RESET. FETCH lasts exactly 3 cycles; ins_load and pc_load pulse only in cycle 3.
- M=3, ADD with funct 0x20 and overflow=0 → reg_write pulses at cycle 6 with regdst=1, mem2reg=1. Repeat with alu_overflow=1 → EXC, epc_load=1, pcin=4, cause=2, no reg_write.
- M=3, LH (0x21) → mdr_load pulses once at cycle 8 and reg_write at cycle 9, adjsz_ctrl=2 throughout. SB (0x28) → mem_write high for exactly cycles 6-8, memow_ctrl=1.
- BEQ with zero=1 → pc_load=1, pcin=1. BNE with zero=1 → pc_load=0. Both return to FETCH after 5 cycles.
- Opcode 0x3F: EN_EXC=1 → EXC with cause=1. EN_EXC=0 → direct FETCH, cause stays 0.
- rst asserted in 2nd MEM_WR cycle → next cycle state RESET and mem_write=0; M=1 build passes the ADD and LW sequences, taking 4 and 5 cycles.
